// File: rtl/axi_sram_read_slave.sv
// AXI4 read responder in front of a single-port synchronous SRAM.
// One AR at a time; one R beat per cycle under continuous RREADY.
module axi_sram_read_slave #(
  parameter int unsigned ID_W    = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [ID_W-1:0]    ARID,
  input  logic [ADDR_W-1:0]  ARADDR,
  input  logic [LEN_W-1:0]   ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_W-1:0]    RID,
  output logic [DATA_W-1:0]  RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               sram_ceb,
  output logic [SRAM_AW-1:0] sram_a,
  input  logic [DATA_W-1:0]  sram_do
);

  localparam int unsigned WIN_LSB = SRAM_AW + 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_DATA} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  incr;
  logic [ADDR_W-1:0]  wrap_mask;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic               burst_err_q;
  logic               ar_wrap_ok;
  logic               ar_err;
  logic               cur_err;
  logic               next_err;
  logic               advance;

  // Burst-level errors are decided once, from the request itself
  assign ar_wrap_ok = (ARLEN != '0) && ((ARLEN & (ARLEN + LEN_W'(1))) == '0);
  assign ar_err     = (ARBURST == BURST_RSVD) || (ARSIZE > 3'd2) ||
                      ((ARBURST == BURST_WRAP) && !ar_wrap_ok);

  assign incr      = ADDR_W'(1) << size_q;
  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);

  always_comb begin
    next_addr = addr_q + incr;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default:     next_addr = addr_q + incr;
    endcase
  end

  assign cur_err  = burst_err_q || (addr_q[ADDR_W-1:WIN_LSB] != '0);
  assign next_err = burst_err_q || (next_addr[ADDR_W-1:WIN_LSB] != '0);
  assign advance  = (state == S_DATA) && RREADY && !RLAST;

  // SRAM is read in RD and, on an accepted non-final beat, for the following beat
  always_comb begin
    sram_ceb = 1'b1;
    sram_a   = addr_q[WIN_LSB-1:2];
    if (state == S_RD) begin
      sram_ceb = cur_err;
    end else if (advance) begin
      sram_ceb = next_err;
      sram_a   = next_addr[WIN_LSB-1:2];
    end
  end

  // sram_do is held while ceb is high, so RDATA stays stable under a stall
  assign RDATA = (RVALID && (RRESP == RESP_OKAY)) ? sram_do : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= S_IDLE;
      ARREADY     <= 1'b0;
      RVALID      <= 1'b0;
      RLAST       <= 1'b0;
      RRESP       <= RESP_OKAY;
      RID         <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      burst_err_q <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ARVALID && ARREADY) begin
            RID         <= ARID;
            addr_q      <= ARADDR;
            len_q       <= ARLEN;
            size_q      <= ARSIZE;
            burst_q     <= ARBURST;
            burst_err_q <= ar_err;
            beat_cnt    <= '0;
            ARREADY     <= 1'b0;
            state       <= S_RD;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        S_RD: begin
          RVALID <= 1'b1;
          RLAST  <= (len_q == '0);
          RRESP  <= cur_err ? RESP_SLVERR : RESP_OKAY;
          state  <= S_DATA;
        end
        S_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              RRESP   <= RESP_OKAY;
              ARREADY <= 1'b1;
              state   <= S_IDLE;
            end else begin
              addr_q   <= next_addr;
              beat_cnt <= beat_cnt + LEN_W'(1);
              RLAST    <= ((beat_cnt + LEN_W'(1)) == len_q);
              RRESP    <= next_err ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Randomized and directed bench for axi_sram_read_slave with an array SRAM
// model and a burst-rule reference model.
module tb_axi_sram_read_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        sram_ceb;
  logic [13:0] sram_a;
  logic [31:0] sram_do = '0;

  logic [31:0] mem [16384];
  int total = 0;
  int bad = 0;

  axi_sram_read_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .sram_ceb(sram_ceb), .sram_a(sram_a), .sram_do(sram_do)
  );

  always #5 ACLK = ~ACLK;

  // Synchronous SRAM: data appears the cycle after ceb low, held otherwise
  always @(posedge ACLK) if (!sram_ceb) sram_do <= mem[sram_a];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a0, input int len,
                                            input int size, input logic [1:0] burst, input int i);
    longint inc = longint'(1) << size;
    longint wl  = longint'(len + 1) * inc;
    longint a   = longint'(a0);
    longint base;
    if (burst == 2'b00) return a0;
    if (burst == 2'b10) begin
      base = (a / wl) * wl;
      return 32'(base + ((a - base) + longint'(i) * inc) % wl);
    end
    return 32'(a + longint'(i) * inc);
  endfunction

  // rmode: 0 = RREADY always high, 1 = random, 2 = 3-cycle stall on beat index 1
  task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst, input int rmode);
    logic [31:0] ea [16];
    logic        eerr [16];
    logic [31:0] ew;
    logic        berr, hs, exp_ceb;
    int t, k, cyc, stall;
    berr = (burst == 2'b11) || (size > 2) ||
           ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int i = 0; i <= len; i++) begin
      ea[i]   = beat_addr(addr, len, size, burst, i);
      eerr[i] = berr || (ea[i] >= 32'h0001_0000);
    end
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = burst;
    ARVALID = 1'b1;
    t = 0;
    hs = 1'b0;
    while (!hs && t < 20) begin
      hs = ARREADY;
      @(posedge ACLK); #1;
      t++;
    end
    ARVALID = 1'b0;
    if (!hs) begin
      check("ar_timeout", 64'(0), 64'(1));
      return;
    end
    k = 0; cyc = 0; stall = 0;
    while (k <= len && cyc < 200) begin
      if (rmode == 0) RREADY = 1'b1;
      else if (rmode == 1) RREADY = ($urandom_range(0, 3) != 0);
      else if (k == 1 && stall < 3) begin RREADY = 1'b0; stall++; end
      else RREADY = 1'b1;
      @(negedge ACLK);
      check("rvalid", 64'(RVALID), 64'(cyc > 0));
      exp_ceb = 1'b1;
      ew = ea[0];
      if (!RVALID) begin
        if (cyc == 0) exp_ceb = eerr[0];
      end else begin
        ew = ea[k];
        check("rdata", 64'(RDATA), eerr[k] ? 64'(0) : 64'(mem[ew[15:2]]));
        check("rid", 64'(RID), 64'(id));
        check("rresp", 64'(RRESP), eerr[k] ? 64'(2) : 64'(0));
        check("rlast", 64'(RLAST), 64'(k == len));
        check("arready_busy", 64'(ARREADY), 64'(0));
        if (RREADY && k < len) begin
          exp_ceb = eerr[k + 1];
          ew = ea[k + 1];
        end
      end
      check("sram_ceb", 64'(sram_ceb), 64'(exp_ceb));
      if (!exp_ceb) check("sram_a", 64'(sram_a), 64'(ew[15:2]));
      if (RVALID && RREADY) k++;
      @(posedge ACLK); #1;
      cyc++;
    end
    if (k <= len) check("r_timeout", 64'(k), 64'(len + 1));
    RREADY = 1'b0;
    check("arready_back", 64'(ARREADY), 64'(1));
    check("rvalid_done", 64'(RVALID), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;
    #1;
    check("rst_arready", 64'(ARREADY), 64'(0));
    check("rst_rvalid", 64'(RVALID), 64'(0));
    check("rst_rlast", 64'(RLAST), 64'(0));
    check("rst_rresp", 64'(RRESP), 64'(0));
    check("rst_rid", 64'(RID), 64'(0));
    check("rst_ceb", 64'(sram_ceb), 64'(1));
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_arready_hold", 64'(ARREADY), 64'(0));
    @(negedge ACLK) ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_arready", 64'(ARREADY), 64'(1));

    run_txn(8'h15, 32'h0000_0010, 0, 2, 2'b01, 0);
    run_txn(8'h21, 32'h0000_0100, 3, 2, 2'b01, 0);
    run_txn(8'h22, 32'h0000_0100, 3, 2, 2'b01, 2);
    run_txn(8'h23, 32'h0000_0038, 3, 2, 2'b10, 0);
    run_txn(8'h24, 32'h0000_0020, 2, 2, 2'b00, 1);
    run_txn(8'h25, 32'h0001_0000, 1, 2, 2'b01, 0);
    run_txn(8'h26, 32'h0000_0040, 2, 2, 2'b11, 0);
    run_txn(8'h27, 32'h0000_0040, 2, 2, 2'b10, 0);
    run_txn(8'h28, 32'h0000_0040, 1, 3, 2'b01, 0);
    run_txn(8'h29, 32'h0000_FFF8, 3, 2, 2'b01, 2);
    run_txn(8'h2A, 32'h0000_0123, 7, 0, 2'b10, 1);

    // Reset in the middle of a 4-beat burst
    ARID = 8'h5A; ARADDR = 32'h200; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    check("mid_rvalid", 64'(RVALID), 64'(1));
    ARESETn = 1'b0;
    #1;
    check("mid_rst_rvalid", 64'(RVALID), 64'(0));
    check("mid_rst_arready", 64'(ARREADY), 64'(0));
    check("mid_rst_ceb", 64'(sram_ceb), 64'(1));
    RREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("rel_arready", 64'(ARREADY), 64'(1));
    check("rel_rvalid", 64'(RVALID), 64'(0));
    run_txn(8'h5B, 32'h0000_0300, 3, 2, 2'b01, 1);

    for (int n = 0; n < 40; n++) begin
      int len, size, sel;
      logic [1:0]  burst;
      logic [31:0] addr;
      sel   = $urandom_range(0, 9);
      burst = (sel < 4) ? 2'b01 : (sel < 7) ? 2'b10 : (sel < 9) ? 2'b00 : 2'b11;
      len   = $urandom_range(0, 15);
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      addr  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(32'hFF80, 32'h10080))
                                          : 32'($urandom_range(0, 32'hFFFF));
      run_txn(8'($urandom), addr, len, size, burst, $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_read_slave.md
Name: axi_sram_read_slave

Overview:
AXI4 read-side responder that sits behind one slave port of the interconnect's read crossbar and serves a single-port synchronous SRAM (IM or DM).
- Accepts one AR request at a time.
- Generates SRAM reads for every beat of the burst.
- Returns R beats with RID echoed, RLAST on the final beat and full backpressure support.
- Sustains one beat per cycle under continuous RREADY.

Parameters:
ID_W, 8, width of ARID/RID (slave-side ID, master ID plus 4 crossbar bits)
ADDR_W, 32, AXI address width
DATA_W, 32, AXI/SRAM data width
LEN_W, 4, ARLEN width (bursts of 1..16 beats)
SRAM_AW, 14, SRAM word-address width (16K words = 64 KB window)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ARID  in  ID_W  read request ID
ARADDR  in  ADDR_W  byte address, already rebased to slave window by crossbar
ARLEN  in  LEN_W  beats minus one
ARSIZE  in  3  bytes per beat = 1<<ARSIZE, max 3'b010
ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ARVALID  in  1  request valid
ARREADY  out  1  request accepted
RID  out  ID_W  response ID
RDATA  out  DATA_W  response data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  final beat
RVALID  out  1  response valid
RREADY  in  1  master ready
sram_ceb  out  1  SRAM chip enable, active low, read-only port
sram_a  out  SRAM_AW  SRAM word address
sram_do  in  DATA_W  SRAM read data; valid the cycle after ceb low, held while ceb high

Behaviour:
- Reset (async, ARESETn=0): state IDLE, ARREADY=0 while in reset, RVALID=0, RLAST=0, RRESP=00, RID=0, sram_ceb=1, beat counter 0, address register 0. A reset asserted mid-burst abandons the burst; no further R beats are issued.
- States and transitions:
  - IDLE: ARREADY=1.
  - IDLE → RD on ARVALID&ARREADY. Latch ARID, ARADDR, ARLEN, ARSIZE, ARBURST; beat_cnt=0.
  - RD: sram_ceb=0, sram_a=cur_addr[SRAM_AW+1:2]; next state DATA.
  - DATA: RVALID=1.
  - DATA with RREADY=0: hold every R output stable and keep sram_ceb=1.
  - DATA with RREADY=1 and !RLAST: advance cur_addr and beat_cnt, drive sram_ceb=0 and sram_a=next word combinationally, stay in DATA (one beat per cycle).
  - DATA with RREADY=1 and RLAST: go to IDLE.
- Latency: AR handshake at edge T → SRAM read cycle T+1 → RVALID=1 in cycle T+2.
- RDATA=sram_do for in-range beats. RID=latched ID. RLAST = (beat_cnt==len_q).
- ARREADY=0 outside IDLE. A new AR is accepted no earlier than the cycle after the last R handshake.
- Address generation (byte address, incr = 1<<size_q):
  - FIXED: address constant.
  - INCR: addr+incr, ADDR_W-bit modulo.
  - WRAP: wrap length = (len_q+1)*incr; low bits wrap within an aligned block of that size. Only len_q ∈ {1,3,7,15} is legal.
- Errors: return SLVERR on every beat of the burst, with RDATA=0 and sram_ceb kept 1 for that beat, in any of these cases:
  - latched ARBURST=11;
  - ARSIZE>2;
  - WRAP with an illegal len;
  - the beat's address ≥ 2^(SRAM_AW+2).
- Error bursts still produce exactly len_q+1 beats with correct RID and RLAST.
- Sub-word sizes return the full aligned word; the master selects lanes.

Test Plan:
- Single read: ARADDR=0x0000_0010, ARLEN=0, ARSIZE=2, INCR, ARID=0x15, SRAM word 4=0xDEADBEEF → RVALID two cycles after handshake, RDATA=0xDEADBEEF, RID=0x15, RLAST=1, RRESP=00; ARREADY returns to 1 the next cycle.
- INCR burst ARADDR=0x100, ARLEN=3, RREADY held 1 → sram_a sequence 0x40,0x41,0x42,0x43, four consecutive RVALID cycles, RLAST only on the 4th beat.
- Backpressure: same burst with RREADY low for 3 cycles on beat 2 → RDATA/RID/RLAST stable, sram_ceb=1 throughout the stall, no beat lost or duplicated.
- WRAP ARADDR=0x38, ARLEN=3, ARSIZE=2 → word addresses 0x0E,0x0F,0x0C,0x0D. FIXED ARADDR=0x20, ARLEN=2 → word 0x08 read three times.
- Error: ARADDR=0x0001_0000, ARLEN=1 → two beats RRESP=10, RDATA=0, RLAST on the 2nd, sram_ceb never low. ARBURST=11 → SLVERR on all beats.
- Reset: deassert ARESETn after beat 1 of a 4-beat burst → RVALID=0 and ARREADY=0 immediately; after release, state IDLE with ARREADY=1, and a new request is served correctly.
